seq_shift_unit: RTL and testbench
=================================

# seq_shift_unit

Multi-cycle shift execution unit in the EX stage of the pipelined datapath. It consumes the zero-extended 32-bit shift amount produced by the ID-stage shift-amount extension stage, together with the rt operand. It performs SLL/SRL/SRA iteratively at up to STEP bit positions per clock. While it works, it holds `busy` to the hazard unit so the pipeline stalls, then presents the result with a one-cycle `done` pulse.

## Interface
- `STEP`, default 1: maximum bit positions shifted per clock. Legal values are 1, 2, 4, 8.
- `Clk` input, 1 bit: single clock; all state updates on the rising edge.
- `Rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request a shift. Sampled only in IDLE.
- `flush` input, 1 bit: synchronous abort, driven from the branch/flush logic.
- `op` input, 2 bits: operation code. 00 SLL, 01 SRL, 10 SRA, 11 PASS (result = operand, no shift).
- `data_in` input, 32 bits: operand to shift (rt value after forwarding).
- `shamt_in` input, 32 bits: zero-extended shift amount. Only bits [4:0] are used; bits [31:5] are ignored.
- `busy` output, 1 bit: unit is occupied (SHIFT or DONE state).
- `done` output, 1 bit: one-cycle pulse; `result` is valid this cycle.
- `result` output, 32 bits: shifted value. Holds its value until the next accepted start.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - SHIFT: `busy`=1, `done`=0.
  - DONE: `busy`=1, `done`=1.
- Accept condition: `start` high and `flush` low while in IDLE.
  - Latch `op`.
  - Load the working register with `data_in`.
  - Load `remaining` with `shamt_in[4:0]`.
  - Next state is SHIFT if `remaining` != 0 and `op` != PASS; otherwise DONE.
- SHIFT, each edge:
  - k = min(STEP, remaining).
  - Working register shifted by k: SLL fills zeros on the left shift, SRL fills zeros on the right shift, SRA fills with bit 31 of the working register.
  - `remaining` -= k.
  - When the new `remaining` = 0, the next state is DONE.
- DONE:
  - `result` is updated with the final working value on entry to DONE.
  - `done` is high for exactly one cycle.
  - Next state is IDLE unconditionally.
- `start` is ignored outside IDLE. The upstream stage holds its instruction because `busy` stalls it.
- `flush` high in SHIFT or DONE: next state is IDLE. `done` does not pulse for the aborted op (a flush in DONE suppresses nothing already seen, because `done` is registered per state). `result` keeps its previous value.
- `flush` and `start` together in IDLE: flush wins; nothing is accepted.
- Reset (`Rst_n`=0, at any time, including mid-operation):
  - State IDLE.
  - `busy`=0, `done`=0.
  - `result`=32'h0.
  - Working register and `remaining` = 0.
  - The in-flight operation is discarded.
- Width rules:
  - `remaining` is 5 bits, and shamt 31 is legal.
  - SRA of a negative operand by 31 gives 32'hFFFFFFFF.
  - No carry-out; shifted-out bits are discarded.

## Timing
- Let n = ceil(shamt_in[4:0] / STEP), with n forced to 0 for PASS.
- Accept at edge k: `done` is high in the cycle following edge k+n.
- Total occupancy is n+1 cycles of `busy`.
- Minimum latency (shamt 0 or PASS): `done` one cycle after the accept edge.
- Maximum latency at STEP=1: shamt 31 gives `done` 31 cycles after accept, and `busy` for 32 cycles.
- Back-to-back: a new `start` can be accepted at the edge that returns DONE to IDLE only if it is still high in the following IDLE cycle. The minimum issue interval is n+2 cycles.
- All outputs are registered (state-decoded from registers); there is no combinational path from inputs to outputs.

## Structure
- Shared package `shift_pkg` holds:
  - `op` encodings: SHOP_SLL, SHOP_SRL, SHOP_SRA, SHOP_PASS.
  - State encoding: ST_IDLE, ST_SHIFT, ST_DONE.
  - The legal STEP set, checked by an elaboration-time assertion.
- One combinational sub-module, `shift_step`, shifts a 32-bit value by k (0..STEP) for a given op. It is instantiated once.
- The top level holds the FSM, the working register, and `remaining`.

## Test plan
- Reset, then `start`, SLL, `data_in`=32'h0000_0001, `shamt_in`=32'h0000_0004, STEP=1: `busy` for 5 cycles, `done` 4 cycles after accept, `result`=32'h0000_0010.
- SRA with `data_in`=32'h8000_0000, `shamt_in`=31 → `result`=32'hFFFF_FFFF. SRL with the same values → `result`=32'h0000_0001. Both at 31-cycle latency (STEP=1), 4-cycle latency at STEP=8.
- `shamt_in`=32'hFFFF_FFE3 (bits [4:0]=3), SLL of 32'h1 → `result`=32'h8. Upper bits ignored.
- `shamt_in`=0, or `op`=PASS with any shamt: `done` one cycle after accept, `result`=`data_in`.
- `flush` in the 2nd SHIFT cycle: returns to IDLE, no `done`, `result` unchanged. A `start` held high during `busy` is not accepted until IDLE.
- `Rst_n` low mid-SHIFT: `busy`, `done`, and `result` go to 0 immediately (asynchronously). After release, a fresh op completes correctly.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit: operation codes, FSM states
// and the set of supported per-clock shift widths.
package shift_pkg;

    typedef enum logic [1:0] {
        SHOP_SLL  = 2'b00,
        SHOP_SRL  = 2'b01,
        SHOP_SRA  = 2'b10,
        SHOP_PASS = 2'b11
    } shop_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DATA_W = 32;
    localparam int SHAMT_W = 5;

    function automatic bit step_is_legal(input int step);
        return (step == 1) || (step == 2) || (step == 4) || (step == 8);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves a 32-bit value by k (0..STEP)
// positions. Only constant shifts up to STEP are built, never a full barrel.
module shift_step
    import shift_pkg::*;
#(
    parameter int STEP = 1
) (
    input  shop_e       i_op,
    input  logic [31:0] i_value,
    input  logic [4:0]  i_k,
    output logic [31:0] o_value
);

    always_comb begin
        o_value = i_value;
        for (int j = 1; j <= STEP; j++) begin
            if (i_k == 5'(j)) begin
                case (i_op)
                    SHOP_SLL: o_value = i_value << j;
                    SHOP_SRL: o_value = i_value >> j;
                    SHOP_SRA: o_value = 32'($signed(i_value) >>> j);
                    default:  o_value = i_value;
                endcase
            end
        end
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle SLL/SRL/SRA unit for the EX stage. Shifts up to STEP positions per
// clock, holds busy to stall the pipeline, and pulses done with the result.
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [1:0]  op,
    input  logic [31:0] data_in,
    input  logic [31:0] shamt_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [1:0]  dbg_state
);

    if (!step_is_legal(STEP)) begin : g_step_check
        $error("seq_shift_unit: STEP must be 1, 2, 4 or 8");
    end

    localparam logic [4:0] STEP_K = 5'(STEP);

    state_e      r_state;
    shop_e       r_op;
    logic [31:0] r_work;
    logic [4:0]  r_remaining;
    logic [31:0] r_result;

    logic [4:0]  w_k;
    logic [4:0]  w_rem_next;
    logic [31:0] w_shifted;
    logic [4:0]  w_shamt;
    logic        w_unused_shamt;

    // Only the low five bits of the extended shift amount carry information.
    assign w_shamt        = shamt_in[4:0];
    assign w_unused_shamt = ^shamt_in[31:5];

    assign w_k        = (r_remaining < STEP_K) ? r_remaining : STEP_K;
    assign w_rem_next = r_remaining - w_k;

    shift_step #(.STEP(STEP)) u_step (
        .i_op    (r_op),
        .i_value (r_work),
        .i_k     (w_k),
        .o_value (w_shifted)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= SHOP_SLL;
            r_work      <= '0;
            r_remaining <= '0;
            r_result    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        r_op        <= shop_e'(op);
                        r_work      <= data_in;
                        r_remaining <= w_shamt;
                        if ((w_shamt != 5'd0) && (shop_e'(op) != SHOP_PASS)) begin
                            r_state <= ST_SHIFT;
                        end else begin
                            r_state  <= ST_DONE;
                            r_result <= data_in;
                        end
                    end
                end
                ST_SHIFT: begin
                    // An aborted op leaves result untouched and never reaches DONE.
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_work      <= w_shifted;
                        r_remaining <= w_rem_next;
                        if (w_rem_next == 5'd0) begin
                            r_state  <= ST_DONE;
                            r_result <= w_shifted;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign result    = r_result;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: a STEP=1 and a STEP=8 instance share stimulus;
// a vector table covers the shift function, hand sequences cover flush/stall/reset.
module tb_seq_shift_unit;
    import shift_pkg::*;

    logic        Clk;
    logic        Rst_n;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [31:0] shamt_in;

    logic        busy1, done1, busy8, done8;
    logic [31:0] result1, result8;
    logic [1:0]  dbg1, dbg8;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [31:0] shamt;
        logic [31:0] exp;
        int          lat1;
        int          lat8;
    } vec_t;

    vec_t vecs[11];

    seq_shift_unit #(.STEP(1)) u_dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .start(start), .flush(flush), .op(op),
        .data_in(data_in), .shamt_in(shamt_in), .busy(busy1), .done(done1),
        .result(result1), .dbg_state(dbg1)
    );

    seq_shift_unit #(.STEP(8)) u_dut8 (
        .Clk(Clk), .Rst_n(Rst_n), .start(start), .flush(flush), .op(op),
        .data_in(data_in), .shamt_in(shamt_in), .busy(busy8), .done(done8),
        .result(result8), .dbg_state(dbg8)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard: every done pulse of the STEP=1 instance consumes one expected result
    always @(posedge Clk) begin
        #1;
        if (Rst_n && done1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_unexpected_done: got %h expected none", result1);
            end else begin
                check("sb_result", result1, exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input vec_t v, input string name);
        int l1, l8, b1, b8, d1, d8;
        l1 = -1; l8 = -1; b1 = 0; b8 = 0; d1 = 0; d8 = 0;
        @(negedge Clk);
        op = v.op; data_in = v.data; shamt_in = v.shamt; start = 1'b1;
        exp_q.push_back(v.exp);
        @(posedge Clk); #1;
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (busy1) b1++;
            if (busy8) b8++;
            if (done1) begin d1++; if (l1 < 0) l1 = c; end
            if (done8) begin d8++; if (l8 < 0) l8 = c; end
            @(posedge Clk); #1;
        end
        check({name, "_result1"}, result1, v.exp);
        check({name, "_result8"}, result8, v.exp);
        check({name, "_lat1"}, 32'(l1), 32'(v.lat1));
        check({name, "_lat8"}, 32'(l8), 32'(v.lat8));
        check({name, "_busy1"}, 32'(b1), 32'(v.lat1 + 1));
        check({name, "_busy8"}, 32'(b8), 32'(v.lat8 + 1));
        check({name, "_ndone1"}, 32'(d1), 32'd1);
        check({name, "_ndone8"}, 32'(d8), 32'd1);
    endtask

    // driver + sequences
    initial begin
        int d1, first_d, second_d;
        vec_t v;

        vecs[0]  = '{2'b00, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 4, 1};
        vecs[1]  = '{2'b10, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 31, 4};
        vecs[2]  = '{2'b01, 32'h8000_0000, 32'd31,        32'h0000_0001, 31, 4};
        vecs[3]  = '{2'b00, 32'h0000_0001, 32'hFFFF_FFE3, 32'h0000_0008, 3, 1};
        vecs[4]  = '{2'b00, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 0, 0};
        vecs[5]  = '{2'b11, 32'h1234_5678, 32'd17,        32'h1234_5678, 0, 0};
        vecs[6]  = '{2'b10, 32'h7000_0000, 32'd8,         32'h0070_0000, 8, 1};
        vecs[7]  = '{2'b10, 32'hF0F0_0000, 32'd12,        32'hFFFF_0F00, 12, 2};
        vecs[8]  = '{2'b01, 32'hF0F0_0000, 32'd12,        32'h000F_0F00, 12, 2};
        vecs[9]  = '{2'b00, 32'h8000_0001, 32'd9,         32'h0000_0200, 9, 2};
        vecs[10] = '{2'b00, 32'h0000_00FF, 32'd31,        32'h8000_0000, 31, 4};

        Rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00;
        data_in = '0; shamt_in = '0;
        repeat (3) @(negedge Clk);
        check("reset_busy1", 32'(busy1), 32'd0);
        check("reset_done1", 32'(done1), 32'd0);
        check("reset_result1", result1, 32'h0);
        check("reset_state1", 32'(dbg1), 32'(ST_IDLE));
        check("reset_result8", result8, 32'h0);
        Rst_n = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // start held high through busy: only re-accepted once back in IDLE
        @(negedge Clk);
        op = 2'b01; data_in = 32'h0000_0100; shamt_in = 32'd3; start = 1'b1;
        exp_q.push_back(32'h0000_0020);
        exp_q.push_back(32'h0000_0100);
        @(posedge Clk); #1;
        data_in = 32'h0000_0800;
        d1 = 0; first_d = -1; second_d = -1;
        for (int c = 0; c < 16; c++) begin
            if (done1) begin
                d1++;
                if (first_d < 0) first_d = c;
                else if (second_d < 0) second_d = c;
            end
            if (c == 4) check("hold_idle_gap", 32'(busy1), 32'd0);
            if (c == 5) start = 1'b0;
            @(posedge Clk); #1;
        end
        check("hold_first_done", 32'(first_d), 32'd3);
        check("hold_second_done", 32'(second_d), 32'd8);
        check("hold_ndone", 32'(d1), 32'd2);
        check("hold_result1", result1, 32'h0000_0100);
        check("hold_result8", result8, 32'h0000_0100);

        // flush in the second SHIFT cycle aborts without done
        @(negedge Clk);
        op = 2'b00; data_in = 32'h0000_0001; shamt_in = 32'd10; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        @(posedge Clk); #1;
        check("flush_in_shift", 32'(dbg1), 32'(ST_SHIFT));
        flush = 1'b1;
        @(posedge Clk); #1;
        flush = 1'b0;
        check("flush_busy1", 32'(busy1), 32'd0);
        check("flush_busy8", 32'(busy8), 32'd0);
        d1 = 0;
        for (int c = 0; c < 12; c++) begin
            if (done1 || done8) d1++;
            @(posedge Clk); #1;
        end
        check("flush_no_done", 32'(d1), 32'd0);
        check("flush_result1", result1, 32'h0000_0100);
        check("flush_result8", result8, 32'h0000_0100);

        // asynchronous reset mid-SHIFT, then a fresh op
        @(negedge Clk);
        op = 2'b00; data_in = 32'h0000_0001; shamt_in = 32'd20; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (3) @(posedge Clk);
        #3;
        check("rst_pre_busy1", 32'(busy1), 32'd1);
        Rst_n = 1'b0;
        #1;
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
        check("rst_result1", result1, 32'h0);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_result8", result8, 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        v = '{2'b00, 32'h0000_0003, 32'd5, 32'h0000_0060, 5, 1};
        run_op(v, "post_reset");

        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
